// File: rtl/sdram_frame_arbiter_pkg.sv
// rtl/sdram_frame_arbiter_pkg.sv - shared types and constants for the SDRAM frame arbiter
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_CMD   = 2'd2
  } state_t;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } grant_t;

  localparam int DEF_MAX_BURST   = 8;
  localparam int DEF_MAX_PENDING = 16;
  localparam int PEND_W          = $clog2(DEF_MAX_PENDING + 1);

endpackage

// File: rtl/sdram_frame_arbiter_if.sv
// rtl/sdram_frame_arbiter_if.sv - Avalon-MM burst port bundle used for both masters and the slave
interface sdram_frame_arbiter_if #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 4
);
  logic [ADDR_W-1:0]  address;
  logic [BURST_W-1:0] burstcount;
  logic               write;
  logic [DATA_W-1:0]  writedata;
  logic               read;
  logic               urgent;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  // Side issuing commands
  modport master (
    output address, burstcount, write, writedata, read, urgent,
    input  waitrequest, readdata, readdatavalid
  );

  // Side accepting commands
  modport slave (
    input  address, burstcount, write, writedata, read, urgent,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_frame_arbiter_pending.sv
// rtl/sdram_frame_arbiter_pending.sv - saturating counter of outstanding read beats
module rd_pending_counter
  import sdram_arb_pkg::*;
#(
  parameter int W   = PEND_W,
  parameter int MAX = DEF_MAX_PENDING,
  parameter int AW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          add_en,
  input  logic [AW-1:0] add_val,
  input  logic          dec,
  output logic [W-1:0]  count
);

  logic [W-1:0] r_count;
  logic [W:0]   w_sum;
  logic [W:0]   w_next;

  // Apply a same-cycle accept and return together; clamp to 0..MAX
  always_comb begin
    w_sum  = {1'b0, r_count} + (add_en ? (W+1)'(add_val) : '0);
    w_next = w_sum;
    if (dec) begin
      w_next = (w_sum == '0) ? '0 : w_sum - (W+1)'(1);
    end
    if (w_next > (W+1)'(MAX)) begin
      w_next = (W+1)'(MAX);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_next[W-1:0];
    end
  end

  // Returned data with nothing outstanding means the slave broke protocol
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(dec && (r_count == '0)))
        else $error("readdatavalid with no outstanding read beats");
    end
  end

  assign count = r_count;

endmodule

// File: rtl/sdram_frame_arbiter.sv
// rtl/sdram_frame_arbiter.sv - burst round-robin arbiter sharing one SDRAM slave between frame writer and reader
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BURST_W     = 4,
  parameter int MAX_BURST   = DEF_MAX_BURST,
  parameter int MAX_PENDING = DEF_MAX_PENDING,
  localparam int PW         = $clog2(MAX_PENDING + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  sdram_frame_arbiter_if.slave   wr,
  sdram_frame_arbiter_if.slave   rd,
  sdram_frame_arbiter_if.master  s,
  output logic [PW-1:0]          pending_beats,
  output logic                   busy
);

  state_t             r_state;
  grant_t             r_last_grant;
  logic [BURST_W-1:0] r_beat_cnt;

  logic [BURST_W-1:0] w_wr_bc;
  logic [BURST_W-1:0] w_rd_bc;
  logic [BURST_W-1:0] w_cnt_now;
  logic [PW:0]        w_rd_need;
  logic               w_rd_ok;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic               w_unused;

  // A burstcount of zero moves one beat
  assign w_wr_bc   = (wr.burstcount == '0) ? BURST_W'(1) : wr.burstcount;
  assign w_rd_bc   = (rd.burstcount == '0) ? BURST_W'(1) : rd.burstcount;
  assign w_rd_need = {1'b0, pending_beats} + (PW+1)'(w_rd_bc);
  assign w_rd_ok   = rd.read && (w_rd_need <= (PW+1)'(MAX_PENDING));
  assign w_wr_acc  = s.write && !s.waitrequest;
  assign w_rd_acc  = s.read && !s.waitrequest;
  // Zero in r_beat_cnt means the burst length has not been latched yet
  assign w_cnt_now = (r_beat_cnt == '0) ? w_wr_bc : r_beat_cnt;

  // Arbitration FSM: grant decided in IDLE, held for a whole write burst or one read command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= READ;
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_beat_cnt <= '0;
          if (rd.urgent && w_rd_ok) begin
            r_state <= RD_CMD;
          end else if (w_rd_ok && wr.write) begin
            r_state <= (r_last_grant == READ) ? WR_BURST : RD_CMD;
          end else if (w_rd_ok) begin
            r_state <= RD_CMD;
          end else if (wr.write) begin
            r_state <= WR_BURST;
          end
        end
        WR_BURST: begin
          if (w_wr_acc) begin
            if (w_cnt_now == BURST_W'(1)) begin
              r_state      <= IDLE;
              r_last_grant <= WRITE;
              r_beat_cnt   <= '0;
            end else begin
              r_beat_cnt <= w_cnt_now - BURST_W'(1);
            end
          end
        end
        RD_CMD: begin
          if (w_rd_acc) begin
            r_state      <= IDLE;
            r_last_grant <= READ;
          end else if (!rd.read) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Slave-side mux: strobes and waitrequests follow the granted port with no added latency
  always_comb begin
    s.address      = wr.address;
    s.burstcount   = wr.burstcount;
    s.writedata    = wr.writedata;
    s.write        = 1'b0;
    s.read         = 1'b0;
    s.urgent       = 1'b0;
    wr.waitrequest = 1'b1;
    rd.waitrequest = 1'b1;
    case (r_state)
      WR_BURST: begin
        s.write        = wr.write;
        wr.waitrequest = s.waitrequest;
      end
      RD_CMD: begin
        s.address      = rd.address;
        s.burstcount   = rd.burstcount;
        s.read         = rd.read;
        rd.waitrequest = s.waitrequest;
      end
      default: ;
    endcase
  end

  assign rd.readdata      = s.readdata;
  assign rd.readdatavalid = s.readdatavalid;
  assign wr.readdata      = '0;
  assign wr.readdatavalid = 1'b0;
  assign w_unused         = ^{wr.read, wr.urgent, rd.write, rd.writedata};

  rd_pending_counter #(
    .W   (PW),
    .MAX (MAX_PENDING),
    .AW  (BURST_W)
  ) u_pending (
    .clk     (clk),
    .reset   (reset),
    .add_en  ((r_state == RD_CMD) && w_rd_acc),
    .add_val (w_rd_bc),
    .dec     (s.readdatavalid),
    .count   (pending_beats)
  );

  assign busy = (r_state != IDLE) || (pending_beats != '0);

  // Bursts longer than the controller supports are a master bug
  always @(posedge clk) begin
    if (!reset) begin
      assert (!((s.write || s.read) && (s.burstcount > BURST_W'(MAX_BURST))))
        else $error("burstcount exceeds MAX_BURST");
    end
  end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// tb/tb_sdram_frame_arbiter.sv - self-checking bench for sdram_frame_arbiter
module tb_sdram_frame_arbiter;
  import sdram_arb_pkg::*;

  logic              clk;
  logic              reset;
  logic [PEND_W-1:0] pending_beats;
  logic              busy;

  sdram_frame_arbiter_if wr_bus ();
  sdram_frame_arbiter_if rd_bus ();
  sdram_frame_arbiter_if s_bus ();

  sdram_frame_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .wr            (wr_bus),
    .rd            (rd_bus),
    .s             (s_bus),
    .pending_beats (pending_beats),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference: who owns the slave, beats left in the write burst, outstanding read beats
  int m_owner;   // 0 none, 1 writer, 2 reader
  int m_left;
  int m_pend;
  int m_last;    // 1 writer served last, 2 reader served last
  logic obs_w, obs_r, prev_w, obs_wwait, obs_rwait;
  int g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic int eff(input int b);
    return (b == 0) ? 1 : b;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_left = 0; m_pend = 0; m_last = 2;
    obs_w = 0; prev_w = 0; obs_r = 0;
  endtask

  task automatic model_step();
    int ok;
    ok = rd_bus.read && (m_pend + eff(rd_bus.burstcount) <= 16);
    if (m_owner == 0) begin
      m_left = 0;
      if (rd_bus.urgent && ok) m_owner = 2;
      else if (ok && wr_bus.write) m_owner = (m_last == 2) ? 1 : 2;
      else if (ok) m_owner = 2;
      else if (wr_bus.write) m_owner = 1;
    end else if (m_owner == 1) begin
      if (wr_bus.write && !s_bus.waitrequest) begin
        if (m_left == 0) m_left = eff(wr_bus.burstcount);
        m_left--;
        if (m_left == 0) begin m_owner = 0; m_last = 1; end
      end
    end else begin
      if (rd_bus.read && !s_bus.waitrequest) begin
        m_owner = 0; m_last = 2; m_pend += eff(rd_bus.burstcount);
      end else if (!rd_bus.read) begin
        m_owner = 0;
      end
    end
    if (s_bus.readdatavalid && m_pend > 0) m_pend--;
  endtask

  // One clock: compare all outputs mid-cycle, then advance the reference at the edge
  task automatic tick();
    logic ew, er;
    @(negedge clk);
    ew = (m_owner == 1) && wr_bus.write;
    er = (m_owner == 2) && rd_bus.read;
    chk("s_write", s_bus.write, ew);
    chk("s_read", s_bus.read, er);
    chk("wr_waitrequest", wr_bus.waitrequest, (m_owner == 1) ? s_bus.waitrequest : 1'b1);
    chk("rd_waitrequest", rd_bus.waitrequest, (m_owner == 2) ? s_bus.waitrequest : 1'b1);
    chk("rd_readdatavalid", rd_bus.readdatavalid, s_bus.readdatavalid);
    chk("rd_readdata", rd_bus.readdata, s_bus.readdata);
    chk("pending_beats", pending_beats, m_pend);
    chk("busy", busy, (m_owner != 0) || (m_pend != 0));
    if (ew) begin
      chk("s_address_wr", s_bus.address, wr_bus.address);
      chk("s_burstcount_wr", s_bus.burstcount, wr_bus.burstcount);
      chk("s_writedata", s_bus.writedata, wr_bus.writedata);
    end
    if (er) begin
      chk("s_address_rd", s_bus.address, rd_bus.address);
      chk("s_burstcount_rd", s_bus.burstcount, rd_bus.burstcount);
    end
    prev_w = obs_w;
    obs_w = s_bus.write;
    obs_r = s_bus.read;
    obs_wwait = wr_bus.waitrequest;
    obs_rwait = rd_bus.waitrequest;
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  // Returns 1 for a new write burst, 2 for a read command, 0 on timeout
  task automatic wait_grant(output int gr);
    gr = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (obs_r) begin gr = 2; break; end
      if (obs_w && !prev_w) begin gr = 1; break; end
    end
  endtask

  task automatic idle_inputs();
    wr_bus.write = 0; wr_bus.read = 0; wr_bus.urgent = 0;
    wr_bus.burstcount = 4'd1; wr_bus.address = '0; wr_bus.writedata = '0;
    rd_bus.read = 0; rd_bus.write = 0; rd_bus.urgent = 0;
    rd_bus.burstcount = 4'd1; rd_bus.address = '0; rd_bus.writedata = '0;
    s_bus.waitrequest = 0; s_bus.readdata = '0; s_bus.readdatavalid = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    do_reset();
    chk("reset_s_write", s_bus.write, 1'b0);
    chk("reset_s_read", s_bus.read, 1'b0);
    chk("reset_wr_wait", wr_bus.waitrequest, 1'b1);
    chk("reset_rd_wait", rd_bus.waitrequest, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_pending", pending_beats, 0);

    // Single 4-beat write burst
    begin
      int nb;
      nb = 0;
      wr_bus.write = 1; wr_bus.burstcount = 4'd4; wr_bus.address = 24'h12_3456; wr_bus.writedata = 16'hbeef;
      tick();
      chk("single_req_cycle_no_strobe", obs_w, 1'b0);
      repeat (4) begin
        tick();
        if (obs_w) nb++;
        wr_bus.writedata = wr_bus.writedata + 16'd1;
      end
      wr_bus.write = 0;
      tick();
      chk("single_idle_s_write", obs_w, 1'b0);
      chk("single_idle_wr_wait", obs_wwait, 1'b1);
      chk("single_beats", nb, 4);
    end

    // Contention from reset: W,R,W,R then the reader hits the cap
    do_reset();
    wr_bus.write = 1; wr_bus.burstcount = 4'd8; wr_bus.address = 24'h00_1000;
    rd_bus.read = 1; rd_bus.burstcount = 4'd8; rd_bus.address = 24'h40_0000;
    wait_grant(g); chk("cont_grant1", g, 1);
    wait_grant(g); chk("cont_grant2", g, 2);
    chk("cont_pend8", pending_beats, 8);
    wait_grant(g); chk("cont_grant3", g, 1);
    wait_grant(g); chk("cont_grant4", g, 2);
    chk("cont_pend16", pending_beats, 16);
    wait_grant(g); chk("cap_grant5", g, 1);
    wait_grant(g); chk("cap_grant6", g, 1);
    s_bus.readdatavalid = 1; s_bus.readdata = 16'h5a5a;
    tick();
    s_bus.readdatavalid = 0;
    chk("cap_pend15", pending_beats, 15);
    wait_grant(g); chk("cap_one_return_still_blocked", g, 1);
    s_bus.readdatavalid = 1;
    repeat (7) begin
      s_bus.readdata = 16'($urandom);
      tick();
    end
    s_bus.readdatavalid = 0;
    chk("cap_pend8", pending_beats, 8);
    wait_grant(g); chk("cap_released_grant", g, 2);
    chk("cap_pend16_again", pending_beats, 16);

    // Drain, then urgency overrides round-robin after a read
    wr_bus.write = 0; rd_bus.read = 0;
    s_bus.readdatavalid = 1;
    repeat (16) tick();
    s_bus.readdatavalid = 0;
    chk("drain_pend0", pending_beats, 0);
    wr_bus.write = 1; rd_bus.read = 1; rd_bus.urgent = 1;
    wait_grant(g); chk("urgent_grant", g, 2);
    rd_bus.read = 0; rd_bus.urgent = 0;
    wait_grant(g); chk("after_urgent_grant", g, 1);
    repeat (7) tick();
    wr_bus.write = 0;
    tick();
    chk("urgent_pend8", pending_beats, 8);

    // Same-cycle accept and return: 5 + 4 - 1 = 8
    s_bus.readdatavalid = 1;
    repeat (3) tick();
    s_bus.readdatavalid = 0;
    chk("simul_pend5", pending_beats, 5);
    rd_bus.read = 1; rd_bus.burstcount = 4'd4;
    tick();
    s_bus.readdatavalid = 1;
    tick();
    chk("simul_accept_seen", obs_r, 1'b1);
    s_bus.readdatavalid = 0; rd_bus.read = 0;
    chk("simul_pend8", pending_beats, 8);
    s_bus.readdatavalid = 1;
    repeat (8) tick();
    s_bus.readdatavalid = 0;

    // Asynchronous reset after 2 of 8 write beats
    wr_bus.write = 1; wr_bus.burstcount = 4'd8;
    wait_grant(g); chk("rst_burst_grant", g, 1);
    tick();
    #2 reset = 1;
    #1;
    chk("rst_s_write_drop", s_bus.write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pending", pending_beats, 0);
    chk("rst_wr_wait", wr_bus.waitrequest, 1'b1);
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    wr_bus.burstcount = 4'd2;
    wait_grant(g); chk("post_rst_grant", g, 1);
    tick();
    chk("post_rst_beat2", obs_w, 1'b1);
    wr_bus.write = 0;
    tick();
    chk("post_rst_done", obs_w, 1'b0);

    // Randomised traffic against the reference
    for (int i = 0; i < 600; i++) begin
      wr_bus.write = ($urandom_range(0, 3) != 0);
      wr_bus.burstcount = 4'($urandom_range(0, 8));
      wr_bus.address = 24'($urandom);
      wr_bus.writedata = 16'($urandom);
      if (m_owner != 2) begin
        rd_bus.read = ($urandom_range(0, 1) != 0);
        rd_bus.burstcount = 4'($urandom_range(1, 8));
        rd_bus.address = 24'($urandom);
      end else begin
        rd_bus.read = ($urandom_range(0, 7) != 0);
      end
      rd_bus.urgent = ($urandom_range(0, 3) == 0);
      s_bus.waitrequest = ($urandom_range(0, 3) == 0);
      s_bus.readdata = 16'($urandom);
      s_bus.readdatavalid = (m_pend > 0) && ($urandom_range(0, 1) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
